// File: rtl/tia_write_strobe_sequencer.sv
// tia_write_strobe_sequencer: clocked TIA write decoder producing one-hot register strobes
// Ports: clk/reset_bar clock and async active-low reset; a, d_in, w_bar, cs CPU write cycle;
// bad_clr clears bad_addr; strobe/strobe_any one-cycle register strobe; d_out latched write data;
// bad_addr sticky unimplemented-address flag; wr_count accepted valid writes modulo 256.
module tia_write_strobe_sequencer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 45,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK = '1,
  parameter int PIPE = 0
) (
  input  logic                  clk,
  input  logic                  reset_bar,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  w_bar,
  input  logic                  cs,
  input  logic                  bad_clr,
  output logic [NUM_REGS-1:0]   strobe,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  strobe_any,
  output logic                  bad_addr,
  output logic [7:0]            wr_count
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic wreq, accept, hit, fire, s1_any;
  logic [ADDR_WIDTH-1:0] ea;
  logic [NUM_REGS-1:0] dec, s1_stb, fire_stb;
  logic [DATA_WIDTH-1:0] s1_data, fire_data;
  // fire selects the edge that raises strobe: the accepting edge, or one later through the s1 stage
  always_comb begin
    wreq = cs & ~w_bar;
    ea = a & ADDR_MASK;
    hit = 32'(ea) < NUM_REGS;
    accept = state == IDLE && wreq;
    dec = hit ? NUM_REGS'(1) << ea : '0;
    fire = PIPE != 0 ? s1_any : accept & hit;
    fire_stb = PIPE != 0 ? s1_stb : dec;
    fire_data = PIPE != 0 ? s1_data : d_in;
  end
  always_ff @(posedge clk or negedge reset_bar)
    if (!reset_bar) begin
      state <= IDLE;
      s1_stb <= '0;
      s1_any <= 1'b0;
      s1_data <= '0;
      strobe <= '0;
      strobe_any <= 1'b0;
      d_out <= '0;
      wr_count <= '0;
      bad_addr <= 1'b0;
    end else begin
      state <= wreq ? HOLD : IDLE;
      s1_stb <= accept ? dec : '0;
      s1_any <= accept & hit;
      s1_data <= accept ? d_in : s1_data;
      strobe <= fire ? fire_stb : '0;
      strobe_any <= fire;
      d_out <= fire ? fire_data : d_out;
      wr_count <= wr_count + 8'(fire);
      // a new bad write outranks a simultaneous clear
      bad_addr <= (accept & ~hit) | (bad_addr & ~bad_clr);
    end
endmodule

// File: tb/tb_tia_write_strobe_sequencer.sv
// tb_tia_write_strobe_sequencer: scoreboard bench over four parameter variants of the sequencer
module tb_tia_write_strobe_sequencer;
  typedef struct {
    int idx;
    logic [7:0] data;
    logic [7:0] cnt;
    int due;
  } exp_t;
  localparam int PIPE_OF[4] = '{0, 0, 1, 1};
  logic clk = 0, reset_bar, w_bar, cs, bad_clr;
  logic [5:0] a;
  logic [7:0] d_in;
  logic [44:0] stb[4];
  logic any[4], bad[4], prev[4];
  logic [7:0] dout[4], cnt[4], ecnt[4];
  exp_t q[4][$];
  exp_t mon_e;
  int cyc = 0, ntests = 0, nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tia_write_strobe_sequencer d0 (.clk(clk), .reset_bar(reset_bar), .a(a), .d_in(d_in), .w_bar(w_bar), .cs(cs),
    .bad_clr(bad_clr), .strobe(stb[0]), .d_out(dout[0]), .strobe_any(any[0]), .bad_addr(bad[0]), .wr_count(cnt[0]));
  tia_write_strobe_sequencer #(.ADDR_MASK(6'h1f)) d1 (.clk(clk), .reset_bar(reset_bar), .a(a), .d_in(d_in),
    .w_bar(w_bar), .cs(cs), .bad_clr(bad_clr), .strobe(stb[1]), .d_out(dout[1]), .strobe_any(any[1]),
    .bad_addr(bad[1]), .wr_count(cnt[1]));
  tia_write_strobe_sequencer #(.ADDR_MASK(6'h1f), .PIPE(1)) d2 (.clk(clk), .reset_bar(reset_bar), .a(a),
    .d_in(d_in), .w_bar(w_bar), .cs(cs), .bad_clr(bad_clr), .strobe(stb[2]), .d_out(dout[2]),
    .strobe_any(any[2]), .bad_addr(bad[2]), .wr_count(cnt[2]));
  tia_write_strobe_sequencer #(.PIPE(1)) d3 (.clk(clk), .reset_bar(reset_bar), .a(a), .d_in(d_in),
    .w_bar(w_bar), .cs(cs), .bad_clr(bad_clr), .strobe(stb[3]), .d_out(dout[3]), .strobe_any(any[3]),
    .bad_addr(bad[3]), .wr_count(cnt[3]));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input int idx, input logic [7:0] data);
    if (idx >= 0) begin
      ecnt[k] = ecnt[k] + 8'd1;
      q[k].push_back('{idx, data, ecnt[k], cyc + 1 + PIPE_OF[k]});
    end
  endtask

  // i0: expected index for mask 3f variants, i1: for mask 1f variants, -1 = bad address
  task automatic wr(input logic [5:0] addr, input logic [7:0] data, input int hold, input int i0,
                    input int i1, input logic clr, input logic rel_cs);
    @(negedge clk);
    a = addr; d_in = data; cs = 1; w_bar = 0; bad_clr = clr;
    push(0, i0, data); push(1, i1, data); push(2, i1, data); push(3, i0, data);
    @(negedge clk);
    bad_clr = 0;
    for (int i = 1; i < hold; i++) begin
      a = addr + 6'd1; d_in = ~data;
      @(negedge clk);
    end
    if (rel_cs) cs = 0; else w_bar = 1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!reset_bar) prev[k] = 0;
      else begin
        if (stb[k] != '0 || any[k]) begin
          ntests++;
          if (q[k].size() == 0) begin
            nfail++;
            $display("FAIL unexpected_strobe dut%0d: strobe=%h any=%b at cycle %0d, none expected", k, stb[k], any[k], cyc);
          end else begin
            mon_e = q[k].pop_front();
            if (stb[k] !== (45'(1) << mon_e.idx) || any[k] !== 1'b1 || dout[k] !== mon_e.data ||
                cnt[k] !== mon_e.cnt || cyc != mon_e.due) begin
              nfail++;
              $display("FAIL pulse dut%0d: got strobe=%h any=%b d_out=%h count=%0d cycle=%0d expected strobe=%h any=1 d_out=%h count=%0d cycle=%0d",
                       k, stb[k], any[k], dout[k], cnt[k], cyc, 45'(1) << mon_e.idx, mon_e.data, mon_e.cnt, mon_e.due);
            end
          end
          ntests++;
          if (prev[k]) begin
            nfail++;
            $display("FAIL pulse_width dut%0d: strobe high on consecutive cycles at cycle %0d, expected 1-cycle pulse", k, cyc);
          end
        end else if (q[k].size() > 0 && q[k][0].due < cyc) begin
          ntests++;
          nfail++;
          $display("FAIL missing_strobe dut%0d: got none by cycle %0d expected index %0d at cycle %0d", k, cyc, q[k][0].idx, q[k][0].due);
          void'(q[k].pop_front());
        end
        prev[k] = stb[k] != '0 || any[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_bar = 0; a = 0; d_in = 0; w_bar = 1; cs = 0; bad_clr = 0;
    for (int k = 0; k < 4; k++) begin ecnt[k] = 0; prev[k] = 0; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_strobe%0d", k), 64'(stb[k]), 0);
      chk($sformatf("rst_any%0d", k), 64'(any[k]), 0);
      chk($sformatf("rst_dout%0d", k), 64'(dout[k]), 0);
      chk($sformatf("rst_bad%0d", k), 64'(bad[k]), 0);
      chk($sformatf("rst_count%0d", k), 64'(cnt[k]), 0);
    end
    reset_bar = 1;
    wr(6'h1B, 8'hA5, 1, 27, 27, 0, 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w1_dout%0d", k), 64'(dout[k]), 64'hA5);
      chk($sformatf("w1_count%0d", k), 64'(cnt[k]), 1);
      chk($sformatf("w1_bad%0d", k), 64'(bad[k]), 0);
    end
    wr(6'h02, 8'h3C, 5, 2, 2, 0, 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold_dout%0d", k), 64'(dout[k]), 64'h3C);
      chk($sformatf("hold_count%0d", k), 64'(cnt[k]), 2);
    end
    wr(6'h30, 8'h11, 1, -1, 16, 0, 0);
    repeat (3) @(negedge clk);
    chk("bad30_flag0", 64'(bad[0]), 1);
    chk("bad30_flag3", 64'(bad[3]), 1);
    chk("bad30_flag1", 64'(bad[1]), 0);
    chk("bad30_dout0", 64'(dout[0]), 64'h3C);
    chk("bad30_count0", 64'(cnt[0]), 2);
    chk("bad30_count3", 64'(cnt[3]), 2);
    chk("mask30_count1", 64'(cnt[1]), 3);
    repeat (3) @(negedge clk);
    chk("bad_sticky0", 64'(bad[0]), 1);
    wr(6'h3F, 8'h22, 1, -1, 31, 1, 0);
    repeat (2) @(negedge clk);
    chk("set_wins0", 64'(bad[0]), 1);
    chk("set_wins3", 64'(bad[3]), 1);
    chk("clr_valid1", 64'(bad[1]), 0);
    bad_clr = 1;
    @(negedge clk);
    bad_clr = 0;
    chk("bad_clr0", 64'(bad[0]), 0);
    chk("bad_clr3", 64'(bad[3]), 0);
    wr(6'h2D, 8'h77, 1, -1, 13, 0, 0);
    repeat (3) @(negedge clk);
    chk("mask2d_bad1", 64'(bad[1]), 0);
    chk("mask2d_bad2", 64'(bad[2]), 0);
    chk("mask2d_dout2", 64'(dout[2]), 64'h77);
    chk("mask2d_count2", 64'(cnt[2]), 5);
    chk("nomask2d_bad0", 64'(bad[0]), 1);
    @(negedge clk);
    a = 6'h05; d_in = 8'h5A; cs = 1; w_bar = 0;
    @(posedge clk);
    #1 reset_bar = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst_strobe%0d", k), 64'(stb[k]), 0);
      chk($sformatf("midrst_dout%0d", k), 64'(dout[k]), 0);
      chk($sformatf("midrst_bad%0d", k), 64'(bad[k]), 0);
      chk($sformatf("midrst_count%0d", k), 64'(cnt[k]), 0);
      ecnt[k] = 0;
    end
    reset_bar = 1;
    for (int k = 0; k < 4; k++) push(k, 5, 8'h5A);
    @(negedge clk);
    w_bar = 1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("postrst_count%0d", k), 64'(cnt[k]), 1);
    for (int i = 0; i < 255; i++) wr(6'(i % 32), 8'(i), 1, i % 32, i % 32, 0, i[0]);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_count%0d", k), 64'(cnt[k]), 0);
      chk($sformatf("pending%0d", k), 64'(q[k].size()), 0);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
